// File: rtl/nibble_serial_adder.sv
// Multi-cycle W-bit adder that streams both operands through one 4-bit
// carry-lookahead slice, LSB nibble first, with the carry held between nibbles.

module adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is flattened to two levels from ci, so none ripples.
    assign c[0] = ci;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign s  = p ^ c[3:0];
    assign co = c[4];
endmodule

module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 ci,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 co,
    output logic                 ovf
);
    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     sum_q, sum_d;
    logic             co_q, co_d;
    logic             ovf_q, ovf_d;

    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [3:0]       slice_s;
    logic             slice_co;
    logic             last_nib;

    assign in_ready  = (state_q == IDLE) & ~rst;
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign co        = co_q;
    assign ovf       = ovf_q;
    assign last_nib  = (idx_q == IDX_W'(NIBBLES - 1));

    // Nibble select by constant-indexed compare keeps every part-select static.
    always_comb begin
        a_nib = a_q[3:0];
        b_nib = b_q[3:0];
        for (int n = 0; n < NIBBLES; n++) begin
            if (idx_q == IDX_W'(n)) begin
                a_nib = a_q[4*n +: 4];
                b_nib = b_q[4*n +: 4];
            end
        end
    end

    adder u_slice (
        .a  (a_nib),
        .b  (b_nib),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_co)
    );

    always_comb begin
        // NOTE: every _d takes its _q value first, so no path through this block can infer a latch.
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        co_d    = co_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = ci;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int n = 0; n < NIBBLES; n++) begin
                    if (idx_q == IDX_W'(n)) begin
                        sum_d[4*n +: 4] = slice_s;
                    end
                end
                carry_d = slice_co;
                if (last_nib) begin
                    co_d    = slice_co;
                    // Carry into the MSB (a^b^s) differs from carry out of it.
                    ovf_d   = a_q[W-1] ^ b_q[W-1] ^ slice_s[3] ^ slice_co;
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder: a 16-bit instance for the directed
// cases and an 8-bit instance for back-to-back transactions against a model.

module tb_nibble_serial_adder;
    logic        clk = 1'b0;
    logic        rst;

    logic        in_valid4, in_ready4, ci4, out_valid4, out_ready4, co4, ovf4;
    logic [15:0] a4, b4, sum4;
    logic        in_valid2, in_ready2, ci2, out_valid2, out_ready2, co2, ovf2;
    logic [7:0]  a2, b2, sum2;

    int tests  = 0;
    int failed = 0;
    int n_in   = 0;
    int n_out  = 0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.NIBBLES(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .ci(ci4), .out_valid(out_valid4), .out_ready(out_ready4),
        .sum(sum4), .co(co4), .ovf(ovf4)
    );

    nibble_serial_adder #(.NIBBLES(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .ci(ci2), .out_valid(out_valid2), .out_ready(out_ready2),
        .sum(sum2), .co(co2), .ovf(ovf2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Wait for the 16-bit result, counting cycles from the handshake edge.
    task automatic wait_result4(input string tag, input logic [15:0] es, input logic eco, input logic eovf);
        int lat = 0;
        int busy_ready = 0;
        while (!out_valid4 && lat < 40) begin
            if (in_ready4) busy_ready++;
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, lat, 4);
        check({tag, " in_ready busy"}, busy_ready + int'(in_ready4), 0);
        check({tag, " sum"}, sum4, es);
        check({tag, " co"}, co4, eco);
        check({tag, " ovf"}, ovf4, eovf);
    endtask

    task automatic add4(input string tag, input logic [15:0] ta, input logic [15:0] tb_v, input logic tci,
                        input logic [15:0] es, input logic eco, input logic eovf);
        int w = 0;
        while (!in_ready4 && w < 40) begin
            @(negedge clk);
            w++;
        end
        check({tag, " in_ready idle"}, in_ready4, 1'b1);
        in_valid4 = 1'b1; a4 = ta; b4 = tb_v; ci4 = tci;
        @(negedge clk);
        in_valid4 = 1'b0; a4 = 16'hDEAD; b4 = 16'hBEEF; ci4 = 1'b1;
        wait_result4(tag, es, eco, eovf);
        out_ready4 = 1'b1;
        @(negedge clk);
        out_ready4 = 1'b0;
        check({tag, " out_valid drop"}, out_valid4, 1'b0);
    endtask

    task automatic add2(input string tag, input logic [7:0] ta, input logic [7:0] tb_v, input logic tci,
                        input logic [7:0] es, input logic eco, input logic eovf, input int hold);
        int lat = 0;
        while (!in_ready2 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        in_valid2 = 1'b1; a2 = ta; b2 = tb_v; ci2 = tci;
        @(negedge clk);
        n_in++;
        in_valid2 = 1'b0; a2 = $urandom; b2 = $urandom; ci2 = $urandom;
        lat = 0;
        while (!out_valid2 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        for (int h = 0; h < hold; h++) begin
            out_ready2 = 1'($urandom) & 1'b0;
            @(negedge clk);
        end
        if (out_valid2) n_out++;
        check({tag, " latency"}, lat, 2);
        check({tag, " sum"}, sum2, es);
        check({tag, " co"}, co2, eco);
        check({tag, " ovf"}, ovf2, eovf);
        out_ready2 = 1'b1;
        @(negedge clk);
        out_ready2 = 1'b0;
    endtask

    initial begin
        logic [8:0] ref9;
        logic [7:0] ra, rb;
        logic       rci, rovf;
        int         hold_cnt;

        rst = 1'b1;
        in_valid4 = 1'b0; a4 = '0; b4 = '0; ci4 = 1'b0; out_ready4 = 1'b0;
        in_valid2 = 1'b0; a2 = '0; b2 = '0; ci2 = 1'b0; out_ready2 = 1'b0;
        repeat (2) @(negedge clk);
        check("reset in_ready", in_ready4, 1'b0);
        check("reset out_valid", out_valid4, 1'b0);
        check("reset sum/co/ovf", {sum4, co4, ovf4}, 18'h0);
        rst = 1'b0;
        @(negedge clk);
        check("post-reset in_ready", in_ready4, 1'b1);

        add4("ffff+1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        add4("7fff+1", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        add4("8000+8000", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        add4("1234+4321+1", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0);

        // Backpressure: result held while new operands wait upstream.
        in_valid4 = 1'b1; a4 = 16'h00FF; b4 = 16'h0001; ci4 = 1'b0;
        @(negedge clk);
        a4 = 16'h1111; b4 = 16'h2222;
        wait_result4("bp 00ff+1", 16'h0100, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp out_valid held", out_valid4, 1'b1);
            check("bp sum held", sum4, 16'h0100);
            check("bp in_ready low", in_ready4, 1'b0);
        end
        out_ready4 = 1'b1;
        @(negedge clk);
        out_ready4 = 1'b0;
        check("bp back to idle", in_ready4, 1'b1);
        @(negedge clk);
        in_valid4 = 1'b0;
        wait_result4("bp next 1111+2222", 16'h3333, 1'b0, 1'b0);
        out_ready4 = 1'b1;
        @(negedge clk);
        out_ready4 = 1'b0;

        // Abort at idx=2 with a live carry, then check it left no residue.
        in_valid4 = 1'b1; a4 = 16'hFFFF; b4 = 16'h0001; ci4 = 1'b0;
        @(negedge clk);
        in_valid4 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort out_valid", out_valid4, 1'b0);
        check("abort in_ready", in_ready4, 1'b0);
        check("abort sum/co/ovf", {sum4, co4, ovf4}, 18'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort idle", {in_ready4, out_valid4}, 2'b10);
        @(negedge clk);
        add4("3+4 after abort", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0);

        // 8-bit instance: directed corners, then back-to-back against a model.
        add2("n2 ff+1", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0);
        add2("n2 7f+0+1", 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1, 1);
        add2("n2 80+ff", 8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1, 2);
        add2("n2 12+34+1", 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0, 0);
        for (int t = 0; t < 1000; t++) begin
            ra = 8'($urandom); rb = 8'($urandom); rci = 1'($urandom);
            ref9 = {1'b0, ra} + {1'b0, rb} + {8'h00, rci};
            rovf = (ra[7] == rb[7]) && (ref9[7] != ra[7]);
            hold_cnt = $urandom_range(0, 3);
            add2("n2 random", ra, rb, rci, ref9[7:0], ref9[8], rovf, hold_cnt);
        end
        check("n2 txn in==out", n_out, n_in);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
